// File: rtl/adc_code_decimator.sv
// adc_code_decimator
//   Decimates the ADC encoder output. It sums windows of 2**LOG2N enabled
//   samples and produces the raw window sum plus a round-half-up mean. Each
//   result goes into a one-entry valid/ready slot. A result that completes
//   while the slot is still full and not being read is discarded, and the
//   loss is counted in a saturating drop counter.
//
//   Optional feature (macro ADC_DEC_MINMAX_EN): adds out_min/out_max, the
//   smallest and largest sample of the window. They are loaded into the slot
//   together with out_sum.
//
// Ports
//   clk        sample clock; all logic is on the rising edge
//   rst        synchronous, active-high reset
//   eout       encoded ADC sample, DW bits
//   en         eout holds a valid sample this cycle
//   clr        clears the open window (accumulator and sample count)
//   out_valid  output slot holds a result
//   out_ready  consumer takes the result when out_valid & out_ready
//   out_data   rounded mean of the window
//   out_sum    raw window sum, DW+LOG2N bits
//   drop_cnt   number of results lost to backpressure (saturating)
//   win_cnt    number of samples taken in the open window
//   out_min    (ADC_DEC_MINMAX_EN) minimum sample of the window
//   out_max    (ADC_DEC_MINMAX_EN) maximum sample of the window
module adc_code_decimator #(
  parameter int DW    = 6,
  parameter int LOG2N = 4,
  parameter int CNTW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       eout,
  input  logic                en,
  input  logic                clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [DW+LOG2N-1:0] out_sum,
  output logic [CNTW-1:0]     drop_cnt,
  output logic [LOG2N-1:0]    win_cnt
`ifdef ADC_DEC_MINMAX_EN
  ,
  output logic [DW-1:0]       out_min,
  output logic [DW-1:0]       out_max
`endif
);

  localparam int SW = DW + LOG2N;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;

  slot_t          state, state_nxt;
  logic [SW-1:0]  acc;
  logic [SW-1:0]  sum;
  logic [SW-1:0]  rnd;
  logic [DW-1:0]  mean;
  logic           complete;
  logic           load;
  logic           drop;

  // Datapath. The window is complete when the sample that fills it arrives.
  // clr overrides a completing sample, so that sample produces no result.
  always_comb begin
    sum      = acc + SW'(eout);
    complete = en && !clr && (win_cnt == '1);
    // The rounding add cannot overflow SW bits: the largest value is
    // (2**DW-1)*N + N/2, which is less than 2**DW * N.
    rnd      = sum + SW'(1 << (LOG2N - 1));
    mean     = rnd[SW-1:LOG2N];
  end

  // Open-window accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (clr || complete) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (en) begin
      acc     <= sum;
      win_cnt <= win_cnt + 1'b1;
    end
  end

  // Slot FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state <= SLOT_EMPTY;
    else     state <= state_nxt;
  end

  // Slot FSM: next state, load and drop decisions.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      SLOT_EMPTY: begin
        if (complete) begin
          load      = 1'b1;
          state_nxt = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (complete) begin
          // A read in the same cycle frees the slot, so the new result
          // replaces the old one.
          if (out_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (out_ready) begin
          state_nxt = SLOT_EMPTY;
        end
      end
      default: state_nxt = SLOT_EMPTY;
    endcase
  end

  // Slot FSM: outputs.
  always_comb begin
    out_valid = (state == SLOT_FULL);
  end

  // Slot payload. It holds its value after the slot empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum  <= '0;
      out_data <= '0;
    end else if (load) begin
      out_sum  <= sum;
      out_data <= mean;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          drop_cnt <= '0;
    else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
  end

`ifdef ADC_DEC_MINMAX_EN
  logic [DW-1:0] run_min, run_max;
  logic [DW-1:0] win_min, win_max;

  // When win_cnt is 0 the sample is the first of a window (after a
  // completion, clr or rst), so it restarts the trackers. This needs no
  // separate "first sample" flag.
  always_comb begin
    win_min = eout;
    win_max = eout;
    if (win_cnt != '0) begin
      if (run_min < eout) win_min = run_min;
      if (run_max > eout) win_max = run_max;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min <= '0;
      run_max <= '0;
    end else if (en) begin
      run_min <= win_min;
      run_max <= win_max;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_min <= '0;
      out_max <= '0;
    end else if (load) begin
      out_min <= win_min;
      out_max <= win_max;
    end
  end
`endif

endmodule
